// File: rtl/rv32i_decode_stage_if.sv
// Bus between fetch, the decode stage and its consumer.
//   in_valid/in_ready   : fetch -> decode handshake carrying in_instr/in_pc
//   out_valid/out_ready : decode -> consumer handshake carrying the decoded fields
// Modports:
//   slave  : the decode stage (takes the input side, drives the output side)
//   master : the environment (fetch plus consumer)
interface rv32i_decode_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [6:0]  out_opcode;
  logic [4:0]  out_rd;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
  logic [31:0] out_imm;
  logic        out_rs1_used;
  logic        out_rs2_used;
  logic        out_rd_we;
  logic        out_illegal;

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2,
           out_funct3, out_funct7, out_imm, out_rs1_used, out_rs2_used,
           out_rd_we, out_illegal
  );

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2,
           out_funct3, out_funct7, out_imm, out_rs1_used, out_rs2_used,
           out_rd_we, out_illegal
  );
endinterface

// File: rtl/rv32i_decode_stage.sv
// RV32I decode stage.
// Decodes a raw 32-bit instruction word into register indices, function
// fields, the sign-extended immediate and read/write usage flags, and flags
// encodings outside the supported RV32I subset. A main register plus one skid
// register give full throughput with a registered in_ready.
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   flush      synchronous flush, drops both buffered entries and any same-cycle input
//   bus        rv32i_decode_stage_if.slave (input and output handshakes plus decoded fields)
//   ill_count  saturating count of illegal entries accepted at the input
module rv32i_decode_stage #(
  parameter int ILL_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  rv32i_decode_stage_if.slave  bus,
  output logic [ILL_CNT_W-1:0] ill_count
);

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_VAR  = 7'b0100000;

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        rs1_used;
    logic        rs2_used;
    logic        rd_we;
    logic        illegal;
  } dec_t;

  dec_t                 dec_next;
  dec_t                 main_reg;
  dec_t                 skid_reg;
  logic                 main_valid_reg;
  logic                 skid_valid_reg;
  logic [ILL_CNT_W-1:0] ill_count_reg;

  logic [31:0] instr;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        in_fire;
  logic        out_fire;

  assign instr = bus.in_instr;
  assign f3    = instr[14:12];
  assign f7    = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'h000};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // Combinational decode of the word currently offered by fetch. Illegal
  // encodings keep imm and the usage flags at their zero defaults.
  always_comb begin
    dec_next          = '0;
    dec_next.pc       = bus.in_pc;
    dec_next.opcode   = instr[6:0];
    dec_next.rd       = instr[11:7];
    dec_next.rs1      = instr[19:15];
    dec_next.rs2      = instr[24:20];
    dec_next.funct3   = f3;
    dec_next.funct7   = f7;
    case (instr[6:0])
      OP_LUI, OP_AUIPC: begin
        dec_next.imm   = imm_u;
        dec_next.rd_we = 1'b1;
      end
      OP_JAL: begin
        dec_next.imm   = imm_j;
        dec_next.rd_we = 1'b1;
      end
      OP_JALR: begin
        if (f3 != 3'b000) begin
          dec_next.illegal = 1'b1;
        end else begin
          dec_next.imm      = imm_i;
          dec_next.rs1_used = 1'b1;
          dec_next.rd_we    = 1'b1;
        end
      end
      OP_BR: begin
        if (f3 == 3'b010 || f3 == 3'b011) begin
          dec_next.illegal = 1'b1;
        end else begin
          dec_next.imm      = imm_b;
          dec_next.rs1_used = 1'b1;
          dec_next.rs2_used = 1'b1;
        end
      end
      OP_LOAD: begin
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) begin
          dec_next.illegal = 1'b1;
        end else begin
          dec_next.imm      = imm_i;
          dec_next.rs1_used = 1'b1;
          dec_next.rd_we    = 1'b1;
        end
      end
      OP_STORE: begin
        if (f3 > 3'b010) begin
          dec_next.illegal = 1'b1;
        end else begin
          dec_next.imm      = imm_s;
          dec_next.rs1_used = 1'b1;
          dec_next.rs2_used = 1'b1;
        end
      end
      OP_IMM: begin
        // Shift-immediates reuse the funct7 slot of the I immediate, so it
        // must hold a legal shift qualifier.
        if ((f3 == 3'b001 && f7 != F7_BASE) ||
            (f3 == 3'b101 && f7 != F7_BASE && f7 != F7_VAR)) begin
          dec_next.illegal = 1'b1;
        end else begin
          dec_next.imm      = imm_i;
          dec_next.rs1_used = 1'b1;
          dec_next.rd_we    = 1'b1;
        end
      end
      OP_REG: begin
        // The variant funct7 only exists for sub and sra.
        if ((f7 != F7_BASE && f7 != F7_VAR) ||
            (f7 == F7_VAR && f3 != 3'b000 && f3 != 3'b101)) begin
          dec_next.illegal = 1'b1;
        end else begin
          dec_next.rs1_used = 1'b1;
          dec_next.rs2_used = 1'b1;
          dec_next.rd_we    = 1'b1;
        end
      end
      default: dec_next.illegal = 1'b1;
    endcase
    if (instr[11:7] == 5'd0) begin
      dec_next.rd_we = 1'b0;
    end
  end

  // in_ready depends only on the skid flag, so it never combinationally
  // follows out_ready.
  assign in_fire  = bus.in_valid & ~skid_valid_reg;
  assign out_fire = main_valid_reg & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_reg <= 1'b0;
      skid_valid_reg <= 1'b0;
      main_reg       <= '0;
      skid_reg       <= '0;
      ill_count_reg  <= '0;
    end else if (flush) begin
      main_valid_reg <= 1'b0;
      skid_valid_reg <= 1'b0;
    end else begin
      if (in_fire && (!main_valid_reg || out_fire)) begin
        // Skid is necessarily empty here, so the new entry is next in line.
        main_reg       <= dec_next;
        main_valid_reg <= 1'b1;
      end else if (in_fire) begin
        skid_reg       <= dec_next;
        skid_valid_reg <= 1'b1;
      end else if (out_fire) begin
        if (skid_valid_reg) begin
          main_reg       <= skid_reg;
          skid_valid_reg <= 1'b0;
        end else begin
          main_valid_reg <= 1'b0;
        end
      end
      if (in_fire && dec_next.illegal && ill_count_reg != '1) begin
        ill_count_reg <= ill_count_reg + ILL_CNT_W'(1);
      end
    end
  end

  assign bus.in_ready     = ~skid_valid_reg;
  assign bus.out_valid    = main_valid_reg;
  assign bus.out_pc       = main_reg.pc;
  assign bus.out_opcode   = main_reg.opcode;
  assign bus.out_rd       = main_reg.rd;
  assign bus.out_rs1      = main_reg.rs1;
  assign bus.out_rs2      = main_reg.rs2;
  assign bus.out_funct3   = main_reg.funct3;
  assign bus.out_funct7   = main_reg.funct7;
  assign bus.out_imm      = main_reg.imm;
  assign bus.out_rs1_used = main_reg.rs1_used;
  assign bus.out_rs2_used = main_reg.rs2_used;
  assign bus.out_rd_we    = main_reg.rd_we;
  assign bus.out_illegal  = main_reg.illegal;
  assign ill_count        = ill_count_reg;

endmodule

// File: tb/tb_rv32i_decode_stage.sv
module tb_rv32i_decode_stage;

  localparam int CW = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic        r1;
    logic        r2;
    logic        wr;
    logic        ill;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic [CW-1:0] ill_count;

  rv32i_decode_stage_if bus ();

  rv32i_decode_stage #(.ILL_CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .bus       (bus.slave),
    .ill_count (ill_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t q[$];
  int   exp_ill = 0;

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decoder: immediates assembled arithmetically from the sign
  // word and shifted bit-groups; legality expressed as the set of allowed
  // funct combinations per opcode.
  function automatic exp_t model(logic [31:0] w, logic [31:0] pc);
    exp_t e;
    logic signed [31:0] sw;
    logic [31:0] sx, ii, is, ib, iu, ij;
    logic [2:0] f3;
    logic [6:0] f7;
    logic legal;
    sw = w;
    sx = sw >>> 31;
    f3 = w[14:12];
    f7 = w[31:25];
    ii = (sx << 12) | 32'(w[31:20]);
    is = (sx << 12) | (32'(w[31:25]) << 5) | 32'(w[11:7]);
    ib = (sx << 12) | (32'(w[7]) << 11) | (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
    iu = w & 32'hFFFF_F000;
    ij = (sx << 20) | (32'(w[19:12]) << 12) | (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
    e = '0;
    e.pc = pc; e.opcode = w[6:0]; e.rd = w[11:7]; e.rs1 = w[19:15];
    e.rs2 = w[24:20]; e.f3 = f3; e.f7 = f7;
    legal = 1'b1;
    case (w[6:0])
      7'h37, 7'h17: begin e.imm = iu; e.wr = 1; end
      7'h6F: begin e.imm = ij; e.wr = 1; end
      7'h67: begin legal = (f3 == 0); e.imm = ii; e.r1 = 1; e.wr = 1; end
      7'h63: begin legal = !(f3 inside {3'd2, 3'd3}); e.imm = ib; e.r1 = 1; e.r2 = 1; end
      7'h03: begin legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}); e.imm = ii; e.r1 = 1; e.wr = 1; end
      7'h23: begin legal = (f3 <= 2); e.imm = is; e.r1 = 1; e.r2 = 1; end
      7'h13: begin
        if (f3 == 1) legal = (f7 == 0);
        else if (f3 == 5) legal = (f7 inside {7'h00, 7'h20});
        e.imm = ii; e.r1 = 1; e.wr = 1;
      end
      7'h33: begin
        legal = (f7 == 0) || (f7 == 7'h20 && f3 inside {3'd0, 3'd5});
        e.r1 = 1; e.r2 = 1; e.wr = 1;
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      e.imm = 0; e.r1 = 0; e.r2 = 0; e.wr = 0;
    end
    if (w[11:7] == 0) e.wr = 0;
    e.ill = !legal;
    return e;
  endfunction

  function automatic exp_t actual();
    return {bus.out_pc, bus.out_opcode, bus.out_rd, bus.out_rs1, bus.out_rs2,
            bus.out_funct3, bus.out_funct7, bus.out_imm, bus.out_rs1_used,
            bus.out_rs2_used, bus.out_rd_we, bus.out_illegal};
  endfunction

  // Monitor / scoreboard: evaluates at the falling edge, where the values
  // seen are those that the next rising edge acts on.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q.delete();
      exp_ill = 0;
    end
    check("out_valid_vs_queue", 128'(bus.out_valid), 128'(q.size() > 0));
    check("in_ready_vs_queue", 128'(bus.in_ready), 128'(q.size() < 2));
    check("ill_count", 128'(ill_count), 128'(exp_ill));
    if (bus.out_valid && q.size() > 0) begin
      check("out_fields", 128'(actual()), 128'(q[0]));
    end
    if (rst_n) begin
      if (flush) begin
        q.delete();
      end else begin
        if (bus.out_valid && bus.out_ready && q.size() > 0) void'(q.pop_front());
        if (bus.in_valid && bus.in_ready) begin
          e = model(bus.in_instr, bus.in_pc);
          q.push_back(e);
          if (e.ill && exp_ill != (1 << CW) - 1) exp_ill++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [10];
    logic [6:0] op;
    logic [6:0] f7;
    logic [31:0] r;
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h00};
    op = ops[$urandom_range(0, 9)];
    if (op == 7'h00) op = 7'($urandom);
    case ($urandom_range(0, 2))
      0: f7 = 7'h00;
      1: f7 = 7'h20;
      default: f7 = 7'($urandom);
    endcase
    r = $urandom;
    return {f7, r[24:7], op};
  endfunction

  task automatic offer(logic [31:0] w, logic [31:0] pc);
    bus.in_valid = 1'b1;
    bus.in_instr = w;
    bus.in_pc    = pc;
    step();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.in_pc     = '0;
    bus.out_ready = 1'b0;
    #2;
    check("reset_data_zero", 128'(actual()), 128'(0));
    check("reset_in_ready", 128'(bus.in_ready), 128'(1));
    step(); step();
    rst_n = 1'b1;
    step();

    // addi x5,x1,-1 then beq x1,x2,-4, each visible one cycle after accept.
    bus.out_ready = 1'b1;
    offer(32'hFFF0_8293, 32'h0000_0100);
    check("addi_valid", 128'(bus.out_valid), 128'(1));
    check("addi_imm", 128'(bus.out_imm), 128'(32'hFFFF_FFFF));
    check("addi_rd_we", 128'({bus.out_rd, bus.out_rs1, bus.out_rd_we, bus.out_rs2_used}),
          128'({5'd5, 5'd1, 1'b1, 1'b0}));
    offer(32'hFE20_8EE3, 32'h0000_0104);
    check("beq_imm", 128'(bus.out_imm), 128'(32'hFFFF_FFFC));
    check("beq_flags", 128'({bus.out_rs1_used, bus.out_rs2_used, bus.out_rd_we}),
          128'(3'b110));
    step();

    // Stall: three offers with out_ready low, only two fit.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_instr = 32'h0010_0093 + (i << 20);
      bus.in_pc    = 32'h200 + 4 * i;
      step();
    end
    bus.in_valid = 1'b0;
    check("stall_in_ready", 128'(bus.in_ready), 128'(0));
    step(); step();
    bus.out_ready = 1'b1;
    step(); step(); step();

    // Reset mid-stream with entries buffered.
    bus.out_ready = 1'b0;
    offer(32'h0000_007F, 32'h300);
    offer(32'h0020_8133, 32'h304);
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", 128'(bus.out_valid), 128'(0));
    check("rst_ill_count", 128'(ill_count), 128'(0));
    step();
    rst_n = 1'b1;
    step();

    // Two illegal words counted.
    bus.out_ready = 1'b1;
    offer(32'h0000_007F, 32'h400);
    check("ill_flag", 128'({bus.out_illegal, bus.out_imm}), 128'({1'b1, 32'h0}));
    offer(32'h4000_2033, 32'h404);
    check("slt_variant_ill", 128'(bus.out_illegal), 128'(1));
    step();
    check("ill_count_two", 128'(ill_count), 128'(2));

    // Flush with both entries full and an input pending.
    bus.out_ready = 1'b0;
    offer(32'hFFF0_8293, 32'h500);
    offer(32'hFFF0_8293, 32'h504);
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h0000_007F;
    flush = 1'b1;
    step();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_out_valid", 128'(bus.out_valid), 128'(0));
    check("flush_in_ready", 128'(bus.in_ready), 128'(1));
    check("flush_ill_count", 128'(ill_count), 128'(2));
    step();

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_instr  = rand_instr();
      bus.in_pc     = $urandom & 32'hFFFF_FFFC;
      bus.out_ready = ($urandom_range(0, 2) != 0);
      flush         = ($urandom_range(0, 63) == 0);
      step();
    end
    bus.in_valid  = 1'b0;
    flush         = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 50 && bus.out_valid; c++) step();
    step();
    check("drain_empty", 128'(q.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
